sim_halt_monitor: RTL
=====================

# sim_halt_monitor

Synthesizable run-control monitor for the pipelined core. It taps the per-stage instruction export buses (IF, DE, EX, MEM, WB) and detects a configurable halt sentinel on a runtime-selected stage. It then drains for a programmable number of cycles before declaring completion, and raises a watchdog timeout if the program never halts. The block replaces ad-hoc testbench halt logic, is usable both in simulation and on the FPGA, and exposes cycle and retired-instruction counts.

## Interface
- `XLEN`, default 32: instruction word width.
- `NUM_CH`, default 5: number of tapped stage channels, 0=IF … 4=WB.
- `HALT_WORD`, default 32'h0000_0001: sentinel instruction encoding.
- `DRAIN_CYCLES`, default 10: cycles from halt detection to `done_o`; 0 is legal.
- `CNT_W`, default 32: width of the counters and of `timeout_i`.
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable_i`, in, 1: run request.
- `instr_i`, in, NUM_CH×XLEN: per-stage instruction words.
- `valid_i`, in, NUM_CH: per-stage word-valid flags.
- `watch_sel_i`, in, $clog2(NUM_CH): index of the watched channel.
- `timeout_i`, in, CNT_W: watchdog limit in cycles; 0 disables the watchdog.
- `halt_o`, out, 1: sentinel has been seen (sticky).
- `done_o`, out, 1: drain complete (sticky).
- `timeout_o`, out, 1: watchdog fired (sticky).
- `state_o`, out, 3: encoded FSM state.
- `cycle_count_o`, out, CNT_W: cycles spent in RUN plus DRAIN.
- `instr_count_o`, out, CNT_W: valid words seen on the watched channel.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE, TIMEOUT.
- IDLE → RUN when `enable_i`=1. Both counters clear on this transition.
- RUN → DRAIN when the watched channel matches: `valid_i[sel]` and `instr_i[sel]==HALT_WORD`. If DRAIN_CYCLES=0, RUN goes directly to DONE instead.
- RUN → TIMEOUT when `timeout_i`≠0 and `cycle_count_o`≥`timeout_i`.
- If a halt match and the timeout condition occur in the same cycle, halt wins.
- DRAIN → DONE when the drain counter expires.
- RUN or DRAIN → IDLE when `enable_i`=0. Counters and `halt_o` hold; `halt_o` clears on the next IDLE→RUN.
- DONE and TIMEOUT are terminal and ignore `enable_i`. Only `reset` exits them.
- `watch_sel_i` is sampled every cycle. A value ≥ NUM_CH never matches and never counts.
- `instr_count_o` increments on each valid watched word while in RUN, including the halt word itself. It does not count in DRAIN.
- `cycle_count_o` increments every cycle in RUN and DRAIN.
- Both counters saturate at all-ones and never wrap.
- Outputs are decoded from registered state only, with no combinational input→output paths.
- Reset values: state=IDLE, all flags 0, both counters 0, drain counter 0.

## Timing
- A halt match sampled at edge t gives `halt_o`=1 after edge t (one-cycle latency).
- `done_o` rises exactly DRAIN_CYCLES cycles after `halt_o` rises.
- With DRAIN_CYCLES=0, `halt_o` and `done_o` rise on the same cycle.
- The watchdog compare uses the registered count, so `timeout_o` rises the cycle after `cycle_count_o` reaches `timeout_i`.
- Asserting `reset` mid-DRAIN forces IDLE immediately, with outputs cleared asynchronously. Release is synchronous to `clk`.

## Structure
- Package `sim_mon_pkg` holds:
  - the `mon_state_t` enum (IDLE=0, RUN=1, DRAIN=2, DONE=3, TIMEOUT=4);
  - the default `HALT_WORD` localparam;
  - the stage index constants `CH_IF`…`CH_WB`.
- Sub-module `sat_counter` (parameter W; ports `clr`, `inc`, `q`) is instantiated for both counters. The drain counter is inline.

## Test plan
- Halt on EX: sel=2, enable, then drive 32'h00000013 for 7 valid cycles, then HALT_WORD. Expect `instr_count_o`=8, `halt_o` the next cycle, `done_o` 10 cycles later, and `cycle_count_o` frozen at 18 in DONE.
- Wrong channel ignored: sel=4, HALT_WORD on channel 2 only. Expect `halt_o` to stay 0 and `instr_count_o`=0.
- Watchdog: `timeout_i`=50, no halt. Expect `timeout_o`=1 with `cycle_count_o`=50 and state=TIMEOUT. Then deassert `enable_i` and confirm the state holds.
- Simultaneous events: HALT_WORD arrives on the exact cycle the timeout condition is true. Expect DRAIN, with `timeout_o`=0.
- DRAIN_CYCLES=0 build: expect `halt_o` and `done_o` to assert in the same cycle.
- Reset mid-DRAIN: pulse `reset` 3 cycles after `halt_o`. Expect all outputs 0 and state IDLE immediately. Re-enable, and confirm the counters restart from 0.

Source files
------------

// File: rtl/sim_mon_pkg.sv
// Shared state encoding and constants for the simulation halt monitor.
package sim_mon_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        DRAIN   = 3'd2,
        DONE    = 3'd3,
        TIMEOUT = 3'd4
    } mon_state_t;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_0001;

    localparam int unsigned CH_IF  = 0;
    localparam int unsigned CH_DE  = 1;
    localparam int unsigned CH_EX  = 2;
    localparam int unsigned CH_MEM = 3;
    localparam int unsigned CH_WB  = 4;

endpackage

// File: rtl/sim_halt_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/sim_halt_monitor.sv
// Run-control monitor: watches one pipeline stage for a halt sentinel,
// drains for a fixed number of cycles, and flags a watchdog timeout.
module sim_halt_monitor
    import sim_mon_pkg::*;
#(
    parameter int unsigned    XLEN         = 32,
    parameter int unsigned    NUM_CH       = 5,
    parameter logic [XLEN-1:0] HALT_WORD   = XLEN'(DEFAULT_HALT_WORD),
    parameter int unsigned    DRAIN_CYCLES = 10,
    parameter int unsigned    CNT_W        = 32,
    localparam int unsigned   SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic [NUM_CH*XLEN-1:0] instr_i,
    input  logic [NUM_CH-1:0]      valid_i,
    input  logic [SEL_W-1:0]       watch_sel_i,
    input  logic [CNT_W-1:0]       timeout_i,
    output logic                   halt_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [2:0]             state_o,
    output logic [CNT_W-1:0]       cycle_count_o,
    output logic [CNT_W-1:0]       instr_count_o
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    mon_state_t         state;
    mon_state_t         state_next;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_cnt_next;
    logic               halt_q;
    logic               done_q;
    logic               timeout_q;
    logic               watch_valid;
    logic [XLEN-1:0]    watch_word;
    logic               halt_match;
    logic               timeout_hit;
    logic               cnt_clr;
    logic               cycle_inc;
    logic               instr_inc;
    logic [CNT_W-1:0]   cycle_count;
    logic [CNT_W-1:0]   instr_count;

    // Out-of-range selects leave watch_valid low, so they never match or count.
    always_comb begin
        watch_valid = 1'b0;
        watch_word  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(watch_sel_i) == i) begin
                watch_valid = valid_i[i];
                watch_word  = instr_i[i*XLEN +: XLEN];
            end
        end
    end

    assign halt_match  = watch_valid && (watch_word == HALT_WORD);
    assign timeout_hit = (timeout_i != '0) && (cycle_count >= timeout_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    // Next state: dropping enable wins in RUN/DRAIN; halt beats the watchdog.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        cnt_clr        = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i) begin
                    state_next = RUN;
                    cnt_clr    = 1'b1;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_next = IDLE;
                end else if (halt_match) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_next = DONE;
                    end else begin
                        state_next     = DRAIN;
                        drain_cnt_next = DRAIN_W'(DRAIN_CYCLES - 32'd1);
                    end
                end else if (timeout_hit) begin
                    state_next = TIMEOUT;
                end
            end
            DRAIN: begin
                if (!enable_i) begin
                    state_next = IDLE;
                end else if (drain_cnt == '0) begin
                    state_next = DONE;
                end else begin
                    drain_cnt_next = drain_cnt - DRAIN_W'(1);
                end
            end
            DONE, TIMEOUT: begin
                state_next = state;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The firing cycle is not counted, so the count freezes at the watchdog limit.
    assign cycle_inc = ((state == RUN) || (state == DRAIN)) && (state_next != TIMEOUT);
    assign instr_inc = (state == RUN) && watch_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (cnt_clr) begin
                halt_q <= 1'b0;
            end else if ((state == RUN) && ((state_next == DRAIN) || (state_next == DONE))) begin
                halt_q <= 1'b1;
            end
            done_q    <= done_q    | (state_next == DONE);
            timeout_q <= timeout_q | (state_next == TIMEOUT);
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cycle_inc),
        .q     (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (instr_inc),
        .q     (instr_count)
    );

    assign halt_o        = halt_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign state_o       = state;
    assign cycle_count_o = cycle_count;
    assign instr_count_o = instr_count;

endmodule
